// File: rtl/rvsteel_spi_pkg.sv
// Shared definitions for the FIFO-buffered SPI controller: register map,
// engine state encodings and STATUS bit positions.
package rvsteel_spi_pkg;

   // Register offsets from BASE_ADDRESS
   localparam logic [31:0] REG_CPOL        = 32'h00;
   localparam logic [31:0] REG_CPHA        = 32'h04;
   localparam logic [31:0] REG_CHIP_SELECT = 32'h08;
   localparam logic [31:0] REG_CLOCK_DIV   = 32'h0C;
   localparam logic [31:0] REG_TXDATA      = 32'h10;
   localparam logic [31:0] REG_RXDATA      = 32'h14;
   localparam logic [31:0] REG_STATUS      = 32'h18;
   localparam logic [31:0] REG_IRQ_ENABLE  = 32'h1C;

   // Value driven on read_data when nothing is being read
   localparam logic [31:0] BUS_DEFAULT = 32'hdeadbeef;

   // One-hot engine states
   typedef enum logic [3:0] {
      ST_IDLE  = 4'b0001,
      ST_LEAD  = 4'b0010,
      ST_TRAIL = 4'b0100,
      ST_DONE  = 4'b1000
   } spi_state_t;

   // STATUS register layout
   localparam int unsigned STATUS_BUSY     = 0;
   localparam int unsigned STATUS_TX_EMPTY = 1;
   localparam int unsigned STATUS_TX_FULL  = 2;
   localparam int unsigned STATUS_RX_EMPTY = 3;
   localparam int unsigned STATUS_RX_FULL  = 4;
   localparam int unsigned STATUS_TX_OVF   = 5;
   localparam int unsigned STATUS_RX_OVR   = 6;
   localparam int unsigned STATUS_WIDTH    = 7;

endpackage

// File: rtl/rvsteel_sync_fifo.sv
// Single-clock FIFO with synchronous reset. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module rvsteel_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign pop_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage array, no reset needed since occupancy gates every read
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/rvsteel_spi_fifo.sv
// Memory-mapped SPI controller with TX/RX FIFOs on the IO bus.
// Optional interrupt output and IRQ_ENABLE register under `SPI_IRQ_EN.
module rvsteel_spi_fifo
   import rvsteel_spi_pkg::*;
#(
   parameter logic [31:0] BASE_ADDRESS = 32'h90000000,
   parameter int unsigned NUM_CS_LINES = 1,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [31:0]             rw_address,
   output logic [31:0]             read_data,
   input  logic                    read_request,
   output logic                    read_response,
   input  logic [31:0]             write_data,
   input  logic [3:0]              write_strobe,
   input  logic                    write_request,
   output logic                    write_response,
   output logic                    sclk,
   output logic                    pico,
   input  logic                    poci,
`ifdef SPI_IRQ_EN
   output logic                    irq,
`endif
   output logic [NUM_CS_LINES-1:0] cs
);

   localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH);
   localparam logic [32:0] DATA_SPAN = 33'(1) << DATA_WIDTH;
   localparam logic [31:0] TX_UPPER_MASK = ~32'(DATA_SPAN - 33'd1);

   // Chip-select decode: line i is low only when CHIP_SELECT equals i
   function automatic logic [NUM_CS_LINES-1:0] cs_decode(input logic [7:0] sel);
      logic [NUM_CS_LINES-1:0] r;
      for (int i = 0; i < NUM_CS_LINES; i++) r[i] = (sel != 8'(i));
      return r;
   endfunction

   logic                    cpol;
   logic                    cpha;
   logic [7:0]              chip_select;
   logic [7:0]              clock_div;
   logic                    tx_ovf;
   logic                    rx_ovr;
   spi_state_t              state;
   logic [DATA_WIDTH-1:0]   tx_shift;
   logic [DATA_WIDTH-1:0]   rx_shift;
   logic [DATA_WIDTH-1:0]   rx_next;
   logic [BIT_CNT_W-1:0]    bit_cnt;
   logic [7:0]              div_cnt;

   logic [31:0]             offset;
   logic                    wr_en;
   logic                    fits_1;
   logic                    fits_3;
   logic                    fits_8;
   logic                    fits_status;
   logic                    fits_tx;
   logic                    busy;
   logic                    cfg_open;
   logic                    cs_open;
   logic                    cs_any;

   logic                    tx_push;
   logic                    tx_pop;
   logic                    tx_full;
   logic                    tx_empty;
   logic [DATA_WIDTH-1:0]   tx_head;
   logic                    rx_push;
   logic                    rx_pop;
   logic                    rx_full;
   logic                    rx_empty;
   logic [DATA_WIDTH-1:0]   rx_head;

   logic [STATUS_WIDTH-1:0] status;
   logic [31:0]             rd_value;

`ifdef SPI_IRQ_EN
   logic [2:0]              irq_enable;
`endif

   assign offset      = rw_address - BASE_ADDRESS;
   assign wr_en       = write_request & (|write_strobe);
   assign fits_1      = (write_data[31:1] == '0);
   assign fits_3      = (write_data[31:3] == '0);
   assign fits_8      = (write_data[31:8] == '0);
   assign fits_status = (write_data[31:STATUS_WIDTH] == '0);
   assign fits_tx     = ((write_data & TX_UPPER_MASK) == '0);

   assign cs_any   = ~(&cs);
   assign busy     = (state != ST_IDLE) | ~tx_empty;
   assign cfg_open = ~busy;
   // While no line is selected no frame can be on the wire, so the target may
   // change even with words queued; otherwise a stalled queue could never drain.
   assign cs_open  = ~busy | ~cs_any;

   assign tx_push = wr_en & (offset == REG_TXDATA) & fits_tx;
   assign tx_pop  = (state == ST_IDLE) & cs_any & ~tx_empty;
   assign rx_push = (state == ST_DONE);
   assign rx_pop  = read_request & (offset == REG_RXDATA) & ~rx_empty;
   assign rx_next = {rx_shift[DATA_WIDTH-2:0], poci};

   assign pico = ((state == ST_IDLE) && !cs_any) ? 1'bz : tx_shift[DATA_WIDTH-1];

   rvsteel_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (tx_push),
      .push_data (write_data[DATA_WIDTH-1:0]),
      .pop       (tx_pop),
      .pop_data  (tx_head),
      .full      (tx_full),
      .empty     (tx_empty)
   );

   rvsteel_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (rx_push),
      .push_data (rx_shift),
      .pop       (rx_pop),
      .pop_data  (rx_head),
      .full      (rx_full),
      .empty     (rx_empty)
   );

   // STATUS vector assembly
   always_comb begin
      status                  = '0;
      status[STATUS_BUSY]     = busy;
      status[STATUS_TX_EMPTY] = tx_empty;
      status[STATUS_TX_FULL]  = tx_full;
      status[STATUS_RX_EMPTY] = rx_empty;
      status[STATUS_RX_FULL]  = rx_full;
      status[STATUS_TX_OVF]   = tx_ovf;
      status[STATUS_RX_OVR]   = rx_ovr;
   end

   // Read mux for the current bus cycle
   always_comb begin
      rd_value = BUS_DEFAULT;
      if (read_request) begin
         case (offset)
            REG_CPOL:        rd_value = {31'b0, cpol};
            REG_CPHA:        rd_value = {31'b0, cpha};
            REG_CHIP_SELECT: rd_value = {24'b0, chip_select};
            REG_CLOCK_DIV:   rd_value = {24'b0, clock_div};
            REG_RXDATA:      rd_value = rx_empty ? 32'h0 : 32'(rx_head);
            REG_STATUS:      rd_value = 32'(status);
`ifdef SPI_IRQ_EN
            REG_IRQ_ENABLE:  rd_value = {29'b0, irq_enable};
`endif
            default:         rd_value = BUS_DEFAULT;
         endcase
      end
   end

   // Bus handshake and registered read data
   always_ff @(posedge clock) begin
      if (reset) begin
         read_response  <= 1'b0;
         write_response <= 1'b0;
         read_data      <= BUS_DEFAULT;
      end else begin
         read_response  <= read_request;
         write_response <= write_request;
         read_data      <= rd_value;
      end
   end

   // Configuration registers, chip selects and sticky error flags
   always_ff @(posedge clock) begin
      if (reset) begin
         cpol        <= 1'b0;
         cpha        <= 1'b0;
         chip_select <= 8'hff;
         cs          <= '1;
         clock_div   <= 8'h00;
         tx_ovf      <= 1'b0;
         rx_ovr      <= 1'b0;
      end else begin
         if (wr_en && offset == REG_CPOL && fits_1 && cfg_open) cpol <= write_data[0];
         if (wr_en && offset == REG_CPHA && fits_1 && cfg_open) cpha <= write_data[0];
         if (wr_en && offset == REG_CLOCK_DIV && fits_8 && cfg_open) clock_div <= write_data[7:0];
         if (wr_en && offset == REG_CHIP_SELECT && fits_8 && cs_open) begin
            chip_select <= write_data[7:0];
            cs          <= cs_decode(write_data[7:0]);
         end
         if (tx_push && tx_full && !tx_pop)
            tx_ovf <= 1'b1;
         else if (wr_en && offset == REG_STATUS && fits_status && write_data[STATUS_TX_OVF])
            tx_ovf <= 1'b0;
         if (rx_push && rx_full && !rx_pop)
            rx_ovr <= 1'b1;
         else if (wr_en && offset == REG_STATUS && fits_status && write_data[STATUS_RX_OVR])
            rx_ovr <= 1'b0;
      end
   end

`ifdef SPI_IRQ_EN
   // Interrupt enable register and registered interrupt line
   always_ff @(posedge clock) begin
      if (reset) begin
         irq_enable <= 3'b000;
         irq        <= 1'b0;
      end else begin
         if (wr_en && offset == REG_IRQ_ENABLE && fits_3) irq_enable <= write_data[2:0];
         irq <= |(irq_enable & {rx_ovr, tx_empty, ~rx_empty});
      end
   end
`else
   logic unused_fits_3;
   assign unused_fits_3 = fits_3;
`endif

   // Shift engine: half-period timing, MSB-first shifting and sampling
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         sclk     <= 1'b0;
         tx_shift <= '0;
         rx_shift <= '0;
         bit_cnt  <= '0;
         div_cnt  <= 8'h00;
      end else begin
         case (state)
            ST_IDLE: begin
               sclk    <= cpol;
               div_cnt <= 8'h00;
               if (tx_pop) begin
                  tx_shift <= tx_head;
                  bit_cnt  <= BIT_CNT_W'(DATA_WIDTH - 1);
                  state    <= ST_LEAD;
                  sclk     <= ~cpol;
               end
            end
            ST_LEAD: begin
               if (div_cnt == clock_div) begin
                  div_cnt <= 8'h00;
                  state   <= ST_TRAIL;
                  sclk    <= cpol;
                  if (!cpha) rx_shift <= rx_next;
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            ST_TRAIL: begin
               if (div_cnt == clock_div) begin
                  div_cnt <= 8'h00;
                  if (cpha) rx_shift <= rx_next;
                  if (bit_cnt == '0) begin
                     state <= ST_DONE;
                     sclk  <= cpol;
                  end else begin
                     bit_cnt  <= bit_cnt - BIT_CNT_W'(1);
                     tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                     state    <= ST_LEAD;
                     sclk     <= ~cpol;
                  end
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               sclk  <= cpol;
            end
            default: begin
               state <= ST_IDLE;
               sclk  <= cpol;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rvsteel_spi_fifo.sv
// Directed bench for rvsteel_spi_fifo: pico looped back to poci, a pull-up
// on the pico net makes the released (Z) state observable.
module tb_rvsteel_spi_fifo;

   localparam logic [31:0] BASE = 32'h90000000;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] rw_address;
   logic [31:0] read_data;
   logic        read_request;
   logic        read_response;
   logic [31:0] write_data;
   logic [3:0]  write_strobe;
   logic        write_request;
   logic        write_response;
   logic        sclk;
   logic [1:0]  cs;
   wire         pico_w;
   wire         poci_w;
`ifdef SPI_IRQ_EN
   logic        irq;
`endif

   pullup (pico_w);
   assign poci_w = pico_w;

   always #5 clock = ~clock;

   rvsteel_spi_fifo #(
      .BASE_ADDRESS (BASE),
      .NUM_CS_LINES (2),
      .DATA_WIDTH   (8),
      .FIFO_DEPTH   (8)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .rw_address     (rw_address),
      .read_data      (read_data),
      .read_request   (read_request),
      .read_response  (read_response),
      .write_data     (write_data),
      .write_strobe   (write_strobe),
      .write_request  (write_request),
      .write_response (write_response),
      .sclk           (sclk),
      .pico           (pico_w),
      .poci           (poci_w),
`ifdef SPI_IRQ_EN
      .irq            (irq),
`endif
      .cs             (cs)
   );

   int   checks = 0;
   int   errors = 0;
   logic last_rresp;
   logic last_wresp;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] off, input logic [31:0] data);
      @(posedge clock); #1;
      rw_address    = BASE + off;
      write_data    = data;
      write_strobe  = 4'hf;
      write_request = 1'b1;
      @(posedge clock); #1;
      write_request = 1'b0;
      write_strobe  = 4'h0;
      last_wresp    = write_response;
   endtask

   task automatic bus_read(input logic [31:0] off, output logic [31:0] data);
      @(posedge clock); #1;
      rw_address   = BASE + off;
      read_request = 1'b1;
      @(posedge clock); #1;
      read_request = 1'b0;
      data         = read_data;
      last_rresp   = read_response;
   endtask

   task automatic read_check(input string tag, input logic [31:0] off, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(off, d);
      check(tag, d, exp);
   endtask

   // Observe sclk/pico for a fixed window: leading-edge count, clocks spent in
   // the leading phase, longest idle-level run between pulses, and pico
   // changes that do not coincide with a leading edge.
   task automatic watch(input int cycles, input logic pol, output int pulses,
                        output int lead, output int max_gap, output int bad);
      logic ps;
      logic pp;
      int   run;
      pulses = 0; lead = 0; max_gap = 0; bad = 0; run = 0;
      ps = sclk; pp = pico_w;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clock); #1;
         if (sclk != pol) begin
            lead++;
            if (ps == pol) begin
               pulses++;
               if (pulses > 1 && run > max_gap) max_gap = run;
            end
            run = 0;
         end else begin
            run++;
         end
         if (pico_w != pp && !(ps == pol && sclk != pol)) bad++;
         ps = sclk;
         pp = pico_w;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int          p, l, g, b;
      logic [31:0] d;
      reset = 1'b1; rw_address = BASE; write_data = '0; write_strobe = '0;
      write_request = 1'b0; read_request = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      // Reset state
      check("rst_cs", 32'(cs), 32'h3);
      check("rst_sclk", 32'(sclk), 32'h0);
      check("rst_pico_z", 32'(pico_w), 32'h1);
      read_check("rst_status", 32'h18, 32'h0A);
      check("read_response", 32'(last_rresp), 32'h1);
      @(posedge clock); #1;
      check("idle_read_data", read_data, 32'hdeadbeef);
      read_check("rst_cs_reg", 32'h08, 32'hff);
      read_check("rst_div", 32'h0C, 32'h0);
`ifdef SPI_IRQ_EN
      read_check("irq_en_reg", 32'h1C, 32'h0);
`else
      read_check("unmapped_1c", 32'h1C, 32'hdeadbeef);
`endif
      read_check("rx_empty_read", 32'h14, 32'h0);

      // Mode 0, DIV=0: one 0xA5 frame, 8 pulses of 1+1 clocks
      bus_write(32'h08, 32'h0);
      check("write_response", 32'(last_wresp), 32'h1);
      check("cs_sel0", 32'(cs), 32'h2);
      bus_write(32'h10, 32'hA5);
      watch(40, 1'b0, p, l, g, b);
      check("m0_pulses", 32'(p), 32'd8);
      check("m0_lead_clks", 32'(l), 32'd8);
      check("m0_trail_clks", 32'(g), 32'd1);
      check("m0_pico_edges", 32'(b), 32'd0);
      read_check("m0_status", 32'h18, 32'h02);
      read_check("m0_rx", 32'h14, 32'hA5);
      read_check("m0_status_after", 32'h18, 32'h0A);

      // Mode 3, DIV=3: sclk idles high, half periods of 4 clocks
      bus_write(32'h00, 32'h1);
      bus_write(32'h04, 32'h1);
      bus_write(32'h0C, 32'h3);
      check("m3_idle_high", 32'(sclk), 32'h1);
      bus_write(32'h10, 32'h3C);
      watch(100, 1'b1, p, l, g, b);
      check("m3_pulses", 32'(p), 32'd8);
      check("m3_lead_clks", 32'(l), 32'd32);
      check("m3_trail_clks", 32'(g), 32'd4);
      check("m3_pico_falling", 32'(b), 32'd0);
      read_check("m3_rx", 32'h14, 32'h3C);

      // Out-of-range field write is ignored; back to mode 0
      bus_write(32'h00, 32'h2);
      read_check("cpol_wide_ignored", 32'h00, 32'h1);
      bus_write(32'h00, 32'h0);
      bus_write(32'h04, 32'h0);
      bus_write(32'h0C, 32'h0);
      bus_write(32'h08, 32'h1);
      check("cs_sel1", 32'(cs), 32'h1);
      bus_write(32'h08, 32'hff);
      check("cs_none", 32'(cs), 32'h3);
      check("pico_released", 32'(pico_w), 32'h1);

      // Stalled queue: FIFO_DEPTH+2 pushes, then release with CS=0
      for (int k = 0; k < 10; k++) bus_write(32'h10, 32'h10 + 32'(k));
      read_check("stall_status", 32'h18, 32'h2D);
      bus_write(32'h0C, 32'h5);
      read_check("div_locked", 32'h0C, 32'h0);
      bus_write(32'h08, 32'h0);
      check("cs_released", 32'(cs), 32'h2);
      // between frames: TRAIL(1) + DONE + IDLE at the idle level
      watch(200, 1'b0, p, l, g, b);
      check("b2b_pulses", 32'(p), 32'd64);
      check("b2b_lead_clks", 32'(l), 32'd64);
      check("b2b_gap", 32'(g), 32'd3);
      check("b2b_pico_edges", 32'(b), 32'd0);
      read_check("b2b_status", 32'h18, 32'h32);
      for (int k = 0; k < 8; k++) begin
         bus_read(32'h14, d);
         check("b2b_rx_order", d, 32'h10 + 32'(k));
      end
      read_check("b2b_status_drained", 32'h18, 32'h2A);
      bus_write(32'h18, 32'h20);
      read_check("tx_ovf_cleared", 32'h18, 32'h0A);

      // RX overrun: FIFO_DEPTH+1 frames without reading
      for (int k = 0; k < 9; k++) bus_write(32'h10, 32'h20 + 32'(k));
      repeat (200) @(posedge clock);
      #1;
      read_check("ovr_status", 32'h18, 32'h52);
      for (int k = 0; k < 8; k++) begin
         bus_read(32'h14, d);
         check("ovr_rx_order", d, 32'h20 + 32'(k));
      end
      read_check("ovr_status_drained", 32'h18, 32'h4A);
      read_check("ovr_extra_lost", 32'h14, 32'h0);
      bus_write(32'h18, 32'h40);
      read_check("rx_ovr_cleared", 32'h18, 32'h0A);

      // Reset in the middle of a frame with another word queued
      bus_write(32'h00, 32'h1);
      bus_write(32'h0C, 32'h2);
      bus_write(32'h10, 32'h81);
      bus_write(32'h10, 32'h42);
      repeat (4) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("midrst_cs", 32'(cs), 32'h3);
      check("midrst_sclk", 32'(sclk), 32'h0);
      check("midrst_pico_z", 32'(pico_w), 32'h1);
      read_check("midrst_status", 32'h18, 32'h0A);
      read_check("midrst_cpol", 32'h00, 32'h0);
      read_check("midrst_div", 32'h0C, 32'h0);
      read_check("midrst_cs_reg", 32'h08, 32'hff);
      repeat (20) @(posedge clock);
      #1;
      check("midrst_sclk_quiet", 32'(sclk), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
